// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable simple-dual-port operand RAM.
package ram_pkg;

   // Byte-enable width for the default 32-bit word; instances derive their own via be_width().
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int BE_WIDTH           = DEFAULT_DATA_WIDTH / 8;

   // Supported read latencies: registered array read, optionally followed by an output register.
   localparam int LAT_ONE = 1;
   localparam int LAT_TWO = 2;

   // Clear-engine state.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // Number of byte lanes in a word of the given width.
   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: sweeps zeros through the whole array after reset release or on request,
// and tells the top to hand the write port over while it does so.
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter int DEEP_LENGTH    = 1024,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr_req,
   output logic                  init_busy,
   output logic                  clr_sel,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEEP_LENGTH - 1);

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  pend_q, pend_d;

   // State register; the pending flag arms an automatic sweep for the first cycle after reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= (CLEAR_ON_RESET != 0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic: clr_req is only honoured from IDLE, so a running sweep never restarts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q || clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are pure functions of the registered state.
   always_comb begin
      init_busy = (state_q == CLEAR);
      clr_sel   = (state_q == CLEAR);
      clr_addr  = cnt_q;
   end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port operand RAM with byte-enable writes, write-first collision bypass,
// 1- or 2-cycle read latency and a hardware clear engine.
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int DEEP_LENGTH    = 1024,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    wea,
   input  logic [DATA_WIDTH/8-1:0] bea,
   input  logic [ADDR_WIDTH-1:0]   addra,
   input  logic [DATA_WIDTH-1:0]   dina,
   input  logic                    reb,
   input  logic [ADDR_WIDTH-1:0]   addrb,
   output logic [DATA_WIDTH-1:0]   doutb,
   output logic                    doutb_valid,
   input  logic                    clr_req,
   output logic                    init_busy
);

   localparam int BW = be_width(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEEP_LENGTH];

   logic                  clr_sel;
   logic [ADDR_WIDTH-1:0] clr_addr;

   logic                  wa_ok, rd_ok, rd_in_range, hit;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BW-1:0]         wr_be;
   logic [DATA_WIDTH-1:0] mem_rd, byp_data;
   logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
   logic                  rd1_valid_q;

   ram_clear_fsm #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DEEP_LENGTH    (DEEP_LENGTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_fsm (
      .clk       (clk),
      .rstn      (rstn),
      .clr_req   (clr_req),
      .init_busy (init_busy),
      .clr_sel   (clr_sel),
      .clr_addr  (clr_addr)
   );

   // User accesses are gated off while the sweep owns the array; out-of-range writes vanish.
   assign wa_ok       = wea && !clr_sel && (int'(addra) < DEEP_LENGTH);
   assign rd_ok       = reb && !clr_sel;
   assign rd_in_range = int'(addrb) < DEEP_LENGTH;
   assign hit         = wa_ok && (addra == addrb);

   // Write-port mux: the clear engine writes a full zero word, otherwise the user write goes through.
   always_comb begin
      wr_en   = wa_ok && (|bea);
      wr_addr = addra;
      wr_data = dina;
      wr_be   = bea;
      if (clr_sel) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
         wr_be   = '1;
      end
   end

   // Byte-lane array write; unselected lanes keep their contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BW; b++) begin
            if (wr_be[b]) begin
               mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign mem_rd = mem[addrb];

   // Write-first bypass: lanes being written this cycle come from dina, the rest from the array.
   genvar gi;
   generate
      for (gi = 0; gi < BW; gi++) begin : g_bypass
         assign byp_data[8*gi +: 8] = (hit && bea[gi]) ? dina[8*gi +: 8] : mem_rd[8*gi +: 8];
      end
   endgenerate

   // Addresses beyond the populated depth read back as zero.
   always_comb begin
      rd1_data_d = rd1_data_q;
      if (rd_ok) begin
         rd1_data_d = rd_in_range ? byp_data : '0;
      end
   end

   // First read stage: data holds when no read is issued, valid is a one-cycle flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd1_data_q  <= '0;
         rd1_valid_q <= 1'b0;
      end else begin
         rd1_data_q  <= rd1_data_d;
         rd1_valid_q <= rd_ok;
      end
   end

   generate
      if (READ_LATENCY == LAT_TWO) begin : g_lat2
         logic [DATA_WIDTH-1:0] rd2_data_q;
         logic                  rd2_valid_q;

         // Optional output register; only reloads when the first stage holds a fresh word.
         always_ff @(posedge clk) begin
            if (!rstn) begin
               rd2_data_q  <= '0;
               rd2_valid_q <= 1'b0;
            end else begin
               if (rd1_valid_q) begin
                  rd2_data_q <= rd1_data_q;
               end
               rd2_valid_q <= rd1_valid_q;
            end
         end

         assign doutb       = rd2_data_q;
         assign doutb_valid = rd2_valid_q;
      end else begin : g_lat1
         assign doutb       = rd1_data_q;
         assign doutb_valid = rd1_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: a full-depth latency-1 instance and a short (1000-word) latency-2
// instance share every input and are both checked against a plain array model.
module tb_ram_sdp_be;

   localparam int D1 = 1024;
   localparam int D2 = 1000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        wea = 1'b0, reb = 1'b0, clr_req = 1'b0;
   logic [3:0]  bea = '0;
   logic [9:0]  addra = '0, addrb = '0;
   logic [31:0] dina = '0;
   logic [31:0] doutb1, doutb2;
   logic        v1, v2, busy1, busy2;

   always #5 clk = ~clk;

   ram_sdp_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEEP_LENGTH(D1), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) u_dut1 (
      .clk(clk), .rstn(rstn), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
      .reb(reb), .addrb(addrb), .doutb(doutb1), .doutb_valid(v1),
      .clr_req(clr_req), .init_busy(busy1)
   );

   ram_sdp_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEEP_LENGTH(D2), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) u_dut2 (
      .clk(clk), .rstn(rstn), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
      .reb(reb), .addrb(addrb), .doutb(doutb2), .doutb_valid(v2),
      .clr_req(clr_req), .init_busy(busy2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory contents plus the last word each output presented.
   logic [31:0] m1 [D1];
   logic [31:0] m2 [D2];
   logic [31:0] last1 = '0, last2 = '0, prev_d2 = '0;
   bit          prev_r = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic zero_model();
      for (int i = 0; i < D1; i++) m1[i] = '0;
      for (int i = 0; i < D2; i++) m2[i] = '0;
   endtask

   // One cycle of user traffic. The write is applied to the model before the read is looked up,
   // which is exactly what write-first means.
   task automatic step(input bit w, input logic [3:0] be, input int aa, input logic [31:0] di,
                       input bit r, input int ab, input string tag);
      logic [31:0] d1, d2, e1, e2;
      wea = w; bea = be; addra = aa[9:0]; dina = di; reb = r; addrb = ab[9:0];
      if (w && aa < D1) m1[aa] = merge(m1[aa], di, be);
      if (w && aa < D2) m2[aa] = merge(m2[aa], di, be);
      d1 = (ab < D1) ? m1[ab] : 32'h0;
      d2 = (ab < D2) ? m2[ab] : 32'h0;
      @(posedge clk); #1;
      e1 = r ? d1 : last1;
      e2 = prev_r ? prev_d2 : last2;
      check($sformatf("%s valid1", tag), 32'(v1), 32'(r));
      check($sformatf("%s dout1", tag), doutb1, e1);
      check($sformatf("%s valid2", tag), 32'(v2), 32'(prev_r));
      check($sformatf("%s dout2", tag), doutb2, e2);
      $display("step %-10s w=%0d be=%h aa=%0d di=%h r=%0d ab=%0d | d1=%h v1=%0d d2=%h v2=%0d",
               tag, w, be, aa, di, r, ab, doutb1, v1, doutb2, v2);
      last1 = e1; last2 = e2; prev_r = r; prev_d2 = d2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 0, "idle");
   endtask

   // Counts init_busy cycles of a full sweep. Optionally launches it with clr_req and pokes a
   // user write to address 3 partway through; reads are issued while both instances are busy.
   task automatic run_sweep(input string tag, input bit pulse, input bit poke);
      int c1 = 0, c2 = 0;
      bit saw_v = 1'b0, done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         clr_req = (c == 0) ? pulse : 1'b0;
         reb     = (c >= 1 && c < 900);
         addrb   = 10'd3;
         wea     = poke && (c == 10);
         bea     = 4'hF; addra = 10'd3; dina = 32'hCAFE_F00D;
         @(posedge clk); #1;
         if (busy1) c1++;
         if (busy2) c2++;
         if (v1 || v2) saw_v = 1'b1;
         if (!busy1 && !busy2 && c1 > 0) done = 1'b1;
      end
      clr_req = 1'b0; reb = 1'b0; wea = 1'b0; bea = 4'h0;
      check($sformatf("%s busy_cycles1", tag), 32'(c1), 32'(D1));
      check($sformatf("%s busy_cycles2", tag), 32'(c2), 32'(D2));
      check($sformatf("%s no_valid_in_sweep", tag), 32'(saw_v), 32'd0);
      $display("sweep %s: busy1=%0d busy2=%0d saw_valid=%0d", tag, c1, c2, saw_v);
      zero_model();
      prev_r = 1'b0;
   endtask

   function automatic int raddr();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(995, 1023)) : int'($urandom_range(0, 31));
   endfunction

   initial begin
      // Reset state
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst dout1", doutb1, 32'h0);
      check("rst valid1", 32'(v1), 32'd0);
      check("rst busy1", 32'(busy1), 32'd0);
      check("rst dout2", doutb2, 32'h0);
      check("rst valid2", 32'(v2), 32'd0);
      check("rst busy2", 32'(busy2), 32'd0);
      rstn = 1'b1;
      run_sweep("por", 1'b0, 1'b0);

      // Cleared contents at low, middle and top addresses
      step(1'b0, 4'h0, 0, 32'h0, 1'b1, 0, "t1_a0");
      step(1'b0, 4'h0, 0, 32'h0, 1'b1, 511, "t1_a511");
      step(1'b0, 4'h0, 0, 32'h0, 1'b1, 1023, "t1_a1023");
      idle(2);

      // Byte-enable merge and read latency
      step(1'b1, 4'hF, 5, 32'hDEADBEEF, 1'b0, 0, "t2_wr1");
      step(1'b1, 4'b0101, 5, 32'h11223344, 1'b0, 0, "t2_wr2");
      step(1'b0, 4'h0, 0, 32'h0, 1'b1, 5, "t2_rd");
      check("t2 const dout1", doutb1, 32'hDE22BE44);
      step(1'b0, 4'h0, 0, 32'h0, 1'b0, 0, "t2_lat2");
      check("t2 const dout2", doutb2, 32'hDE22BE44);
      idle(1);

      // Same-cycle collision is write-first with byte merge
      step(1'b1, 4'hF, 7, 32'h12345678, 1'b0, 0, "t3_init");
      step(1'b1, 4'b0011, 7, 32'hAAAAAAAA, 1'b1, 7, "t3_coll");
      check("t3 const dout1", doutb1, 32'h1234AAAA);
      idle(2);

      // Full-throughput concurrent read and write streams
      for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 16 + i, $urandom, 1'b1, i, "t4_rw");
      for (int i = 16; i < 32; i++) step(1'b0, 4'h0, 0, 32'h0, 1'b1, i, "t4_rd");
      idle(2);

      // Requested sweep ignores user writes, then reset aborts a sweep and it restarts
      run_sweep("clr_req", 1'b1, 1'b1);
      step(1'b0, 4'h0, 0, 32'h0, 1'b1, 3, "t5_rd3");
      check("t5 const dout1", doutb1, 32'h0);
      idle(2);
      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      check("t5 busy_started", 32'(busy1), 32'd1);
      repeat (511) @(posedge clk);
      #1;
      check("t5 busy_mid", 32'(busy1), 32'd1);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("t5 abort busy1", 32'(busy1), 32'd0);
      check("t5 abort busy2", 32'(busy2), 32'd0);
      check("t5 abort dout1", doutb1, 32'h0);
      check("t5 abort dout2", doutb2, 32'h0);
      last1 = '0; last2 = '0; prev_r = 1'b0;
      rstn = 1'b1;
      run_sweep("restart", 1'b0, 1'b0);

      // Out-of-range access on the 1000-word instance
      step(1'b1, 4'hF, 1010, 32'h5A5A5A5A, 1'b1, 1010, "t6_wr");
      step(1'b0, 4'h0, 0, 32'h0, 1'b1, 1010, "t6_rd");
      check("t6 const valid2", 32'(v2), 32'd1);
      check("t6 const dout2", doutb2, 32'h0);
      idle(2);

      // Random traffic biased towards collisions and the out-of-range window
      for (int i = 0; i < 400; i++) begin
         int aa, ab;
         aa = raddr();
         ab = ($urandom_range(0, 2) == 0) ? aa : raddr();
         step(1'($urandom), 4'($urandom), aa, $urandom, 1'($urandom), ab, "rand");
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
Parametrised simple-dual-port block RAM, the successor to the plain single-write/single-read RSA operand RAM. Adds per-byte write enables, an explicit read enable with valid flag, selectable read latency (1 or 2), write-first collision bypass, and a hardware clear engine that zeroes the array after reset or on request. Holds the modulus, exponent and intermediate Montgomery operands between the AXI slave and the modular-multiply datapath.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, address width.
DEEP_LENGTH, 1024, number of words; must satisfy DEEP_LENGTH <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from reb to doutb_valid; legal values are 1 or 2 (2 adds an output register).
CLEAR_ON_RESET, 1, when set to 1, starts a clear sweep automatically after reset release.

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
wea  input  1  write enable, port A
bea  input  DATA_WIDTH/8  byte enables for the port-A write; bit i covers dina[8i+7:8i]
addra  input  ADDR_WIDTH  write address
dina  input  DATA_WIDTH  write data
reb  input  1  read enable, port B
addrb  input  ADDR_WIDTH  read address
doutb  output  DATA_WIDTH  read data
doutb_valid  output  1  doutb carries the result of a reb issued READ_LATENCY cycles earlier
clr_req  input  1  one-cycle pulse that requests a full clear sweep
init_busy  output  1  clear sweep in progress; port accesses are ignored while high

Behaviour:
- One clock. Reset is synchronous and active-low: every register updates only on the rising edge of clk, and rstn is sampled on that edge.
- Reset values: doutb=0, doutb_valid=0, all pipeline stages=0, init_busy=0, FSM=IDLE. Array contents are not reset directly; the clear engine handles them.
- FSM states:
  - IDLE: moves to CLEAR in the cycle after reset release when CLEAR_ON_RESET=1, or on clr_req.
  - CLEAR: writes 0 to address clr_cnt, one word per cycle, counting 0..DEEP_LENGTH-1. On the last word goes to IDLE. init_busy is high for exactly DEEP_LENGTH cycles.
- During CLEAR:
  - wea and reb are masked. No user write occurs, and doutb_valid stays 0.
  - clr_req is ignored (no restart).
- Reset asserted mid-CLEAR aborts the sweep and clears the counter. The sweep restarts after release if CLEAR_ON_RESET=1.
- Write: when wea=1 and addra < DEEP_LENGTH, each byte i with bea[i]=1 is updated; all other bytes are kept.
  - Writes with addra >= DEEP_LENGTH are dropped silently.
  - bea=0 with wea=1 is a no-op.
- Read: reb=1 captures addrb.
  - READ_LATENCY=1: doutb and doutb_valid are updated on the next edge.
  - READ_LATENCY=2: the result passes through one more register stage.
  - A read with addrb >= DEEP_LENGTH returns 0 with valid=1.
  - When reb=0, doutb holds its last value and doutb_valid=0 for the matching cycle.
- Collision (wea=1, reb=1, addra==addrb in the same cycle): the read is write-first. The returned word takes the new bytes where bea=1 and the old bytes elsewhere.
- Reads and writes run concurrently at full throughput: one read and one write per cycle, back-to-back, no bubbles.

Decomposition:
- Package ram_pkg:
  - localparam BE_WIDTH = DATA_WIDTH/8
  - FSM state typedef (IDLE, CLEAR)
  - legal READ_LATENCY constants
- Sub-module ram_clear_fsm: owns the state, clr_cnt and init_busy, and drives the write-port mux select.
- The top module holds the array, the byte-merge logic, the collision bypass and the read pipeline.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1, DEEP_LENGTH=1024 -> init_busy high for exactly 1024 cycles; afterwards, reads of addresses 0, 511 and 1023 return 0x00000000 with valid.
2. Write 0xDEADBEEF to addr 5 (bea=4'hF), then write 0x11223344 to addr 5 with bea=4'b0101, then read addr 5 -> 0xDE22BE44; doutb_valid rises 1 cycle after reb (LATENCY=1) and 2 cycles after reb in a LATENCY=2 build.
3. Same cycle: wea=1, addra=7, dina=0xAAAAAAAA, bea=4'b0011; reb=1, addrb=7; old content 0x12345678 -> doutb=0x1234AAAA.
4. Back-to-back reads of addrs 0..15 while writing addrs 16..31 -> 16 consecutive valid words with no gaps; contents of 16..31 verified afterwards.
5. Pulse clr_req, then drive wea=1 to addr 3 during the sweep -> the write is dropped and addr 3 reads 0 after init_busy falls. Assert rstn=0 halfway through the sweep -> init_busy=0 next edge, and a full 1024-cycle sweep restarts after release.
6. DEEP_LENGTH=1000, ADDR_WIDTH=10: write addr 1010 and read addr 1010 -> no array change, doutb=0 with valid=1.
